// File: rtl/i2c_write_sequencer_if.sv
// Bus between the write sequencer and the single-byte I2C write engine.
interface i2c_write_sequencer_if;
    logic [7:0] slave_address;
    logic [7:0] slave_register;
    logic [7:0] slave_data;
    logic       enable_send_n;
    logic       eng_busy_n;
    logic [7:0] eng_status;

    modport master (
        output slave_address, slave_register, slave_data, enable_send_n,
        input  eng_busy_n, eng_status
    );

    modport slave (
        input  slave_address, slave_register, slave_data, enable_send_n,
        output eng_busy_n, eng_status
    );
endinterface

// File: rtl/i2c_write_sequencer.sv
// Walks a ROM of (address, register, data) writes through the I2C write engine,
// retrying NACKed or timed-out attempts and flagging the first entry that never succeeds.
module i2c_write_sequencer #(
    parameter int N_ENTRIES  = 16,
    parameter int MAX_RETRY  = 3,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                         clock_i2c,
    input  logic                         reset,
    input  logic                         start,
    output logic [7:0]                   tbl_index,
    input  logic [7:0]                   tbl_addr,
    input  logic [7:0]                   tbl_reg,
    input  logic [7:0]                   tbl_data,
    i2c_write_sequencer_if.master        eng,
    output logic                         done,
    output logic                         error,
    output logic [7:0]                   fail_index,
    output logic [7:0]                   last_status,
    output logic [3:0]                   retry_count
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_ASSERT, S_WAIT_START, S_WAIT_DONE,
        S_CHECK, S_RELEASE, S_GAP, S_DONE, S_ERROR
    } state_t;

    // One timer serves both the wait timeouts and the inter-transaction gap.
    localparam int TMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TIMEOUT_V  = TW'(TIMEOUT);
    localparam logic [TW-1:0] GAP_LAST_V = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE      = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [7:0]    LAST_IDX   = 8'(N_ENTRIES - 1);
    localparam logic [3:0]    MAX_RETRY_V = 4'(MAX_RETRY);
    localparam logic [7:0]    ACK_STATUS = 8'h2A;

    state_t          state_r, state_nxt_s;
    logic [TW-1:0]   timer_r, timer_nxt_s;
    logic            timeout_r, timeout_nxt_s;
    logic            last_pass_r, last_pass_nxt_s;
    logic            fail_flag_r, fail_flag_nxt_s;
    logic [7:0]      index_nxt_s, fail_index_nxt_s, last_status_nxt_s;
    logic [7:0]      addr_nxt_s, reg_nxt_s, data_nxt_s;
    logic [3:0]      retry_nxt_s;
    logic            en_n_nxt_s, done_nxt_s, error_nxt_s;

    // FSM state register.
    always_ff @(posedge clock_i2c) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-register-value logic.
    always_comb begin
        state_nxt_s       = state_r;
        timer_nxt_s       = timer_r;
        timeout_nxt_s     = timeout_r;
        last_pass_nxt_s   = last_pass_r;
        fail_flag_nxt_s   = fail_flag_r;
        index_nxt_s       = tbl_index;
        fail_index_nxt_s  = fail_index;
        last_status_nxt_s = last_status;
        retry_nxt_s       = retry_count;
        addr_nxt_s        = eng.slave_address;
        reg_nxt_s         = eng.slave_register;
        data_nxt_s        = eng.slave_data;
        en_n_nxt_s        = eng.enable_send_n;
        done_nxt_s        = done;
        error_nxt_s       = error;
        case (state_r)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_nxt_s = S_LOAD;
                    done_nxt_s  = 1'b0;
                    error_nxt_s = 1'b0;
                    retry_nxt_s = 4'd0;
                    index_nxt_s = 8'd0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_LOAD: begin
                addr_nxt_s  = tbl_addr;
                reg_nxt_s   = tbl_reg;
                data_nxt_s  = tbl_data;
                state_nxt_s = S_ASSERT;
            end
            S_ASSERT: begin
                en_n_nxt_s    = 1'b0;
                timer_nxt_s   = {TW{1'b0}};
                timeout_nxt_s = 1'b0;
                state_nxt_s   = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (!eng.eng_busy_n) begin
                    timer_nxt_s = {TW{1'b0}};
                    state_nxt_s = S_WAIT_DONE;
                end else if (timer_r == TIMEOUT_V) begin
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = S_CHECK;
                end else begin
                    timer_nxt_s = timer_r + T_ONE;
                end
            end
            S_WAIT_DONE: begin
                if (eng.eng_busy_n) begin
                    state_nxt_s = S_CHECK;
                end else if (timer_r == TIMEOUT_V) begin
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = S_CHECK;
                end else begin
                    timer_nxt_s = timer_r + T_ONE;
                end
            end
            S_CHECK: begin
                last_status_nxt_s = eng.eng_status;
                last_pass_nxt_s   = 1'b0;
                fail_flag_nxt_s   = 1'b0;
                if ((eng.eng_status == ACK_STATUS) && !timeout_r) begin
                    retry_nxt_s = 4'd0;
                    if (tbl_index == LAST_IDX) begin
                        last_pass_nxt_s = 1'b1;
                    end else begin
                        index_nxt_s = tbl_index + 8'd1;
                    end
                end else if (retry_count < MAX_RETRY_V) begin
                    retry_nxt_s = retry_count + 4'd1;
                end else begin
                    fail_index_nxt_s = tbl_index;
                    fail_flag_nxt_s  = 1'b1;
                end
                state_nxt_s = S_RELEASE;
            end
            S_RELEASE: begin
                en_n_nxt_s = 1'b1;
                if (fail_flag_r) begin
                    error_nxt_s = 1'b1;
                    state_nxt_s = S_ERROR;
                end else if (last_pass_r) begin
                    done_nxt_s  = 1'b1;
                    state_nxt_s = S_DONE;
                end else begin
                    timer_nxt_s = {TW{1'b0}};
                    state_nxt_s = S_GAP;
                end
            end
            S_GAP: begin
                if (timer_r == GAP_LAST_V) begin
                    state_nxt_s = S_LOAD;
                end else begin
                    timer_nxt_s = timer_r + T_ONE;
                end
            end
            default: begin
                en_n_nxt_s  = 1'b1;
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers; reset also drops the engine request at once.
    always_ff @(posedge clock_i2c) begin
        if (!reset) begin
            timer_r            <= {TW{1'b0}};
            timeout_r          <= 1'b0;
            last_pass_r        <= 1'b0;
            fail_flag_r        <= 1'b0;
            tbl_index          <= 8'd0;
            fail_index         <= 8'd0;
            last_status        <= 8'd0;
            retry_count        <= 4'd0;
            eng.slave_address  <= 8'd0;
            eng.slave_register <= 8'd0;
            eng.slave_data     <= 8'd0;
            eng.enable_send_n  <= 1'b1;
            done               <= 1'b0;
            error              <= 1'b0;
        end else begin
            timer_r            <= timer_nxt_s;
            timeout_r          <= timeout_nxt_s;
            last_pass_r        <= last_pass_nxt_s;
            fail_flag_r        <= fail_flag_nxt_s;
            tbl_index          <= index_nxt_s;
            fail_index         <= fail_index_nxt_s;
            last_status        <= last_status_nxt_s;
            retry_count        <= retry_nxt_s;
            eng.slave_address  <= addr_nxt_s;
            eng.slave_register <= reg_nxt_s;
            eng.slave_data     <= data_nxt_s;
            eng.enable_send_n  <= en_n_nxt_s;
            done               <= done_nxt_s;
            error              <= error_nxt_s;
        end
    end
endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Bench: a 3-entry sequencer against a behavioural engine, plus a 1-entry sequencer
// whose engine handshake is driven by hand for exact cycle checks.
module tb_i2c_write_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic a_start, b_start;
    logic [7:0] a_idx, a_taddr, a_treg, a_tdata, b_idx;
    logic a_done, a_error, b_done, b_error;
    logic [7:0] a_fidx, a_last, b_fidx, b_last;
    logic [3:0] a_retry, b_retry;

    i2c_write_sequencer_if a_if ();
    i2c_write_sequencer_if b_if ();

    i2c_write_sequencer #(.N_ENTRIES(3), .MAX_RETRY(2), .GAP_CYCLES(4), .TIMEOUT(10)) dut_a (
        .clock_i2c(clk), .reset(reset), .start(a_start), .tbl_index(a_idx),
        .tbl_addr(a_taddr), .tbl_reg(a_treg), .tbl_data(a_tdata), .eng(a_if),
        .done(a_done), .error(a_error), .fail_index(a_fidx), .last_status(a_last),
        .retry_count(a_retry));

    i2c_write_sequencer #(.N_ENTRIES(1), .MAX_RETRY(0), .GAP_CYCLES(2), .TIMEOUT(10)) dut_b (
        .clock_i2c(clk), .reset(reset), .start(b_start), .tbl_index(b_idx),
        .tbl_addr(8'h3C), .tbl_reg(8'h55), .tbl_data(8'hA5), .eng(b_if),
        .done(b_done), .error(b_error), .fail_index(b_fidx), .last_status(b_last),
        .retry_count(b_retry));

    function automatic logic [7:0] exp_data(input int e);
        case (e)
            0: exp_data = 8'hAE;
            1: exp_data = 8'h10;
            2: exp_data = 8'hFF;
            default: exp_data = 8'h00;
        endcase
    endfunction

    always_comb begin
        a_taddr = 8'h78;
        a_treg  = a_idx;
        a_tdata = exp_data(int'(a_idx));
        if (a_idx > 8'd2) begin
            a_taddr = 8'h00;
            a_treg  = 8'h00;
        end
    end

    // Behavioural engine for dut_a: busy for busy_len cycles, NACKs a chosen entry.
    bit eng_rst = 1'b1;
    bit hang = 1'b0;
    int busy_len = 4;
    int fail_entry = 0, fail_times = 0, fails_done = 0, eng_st = 0, eng_cnt = 0;
    logic [7:0] fail_code = 8'h00;
    logic [7:0] sent_addr[$], sent_reg[$], sent_data[$];

    always @(negedge clk) begin
        if (eng_rst) begin
            eng_st = 0; fails_done = 0;
            a_if.eng_busy_n = 1'b1; a_if.eng_status = 8'h00;
            sent_addr.delete(); sent_reg.delete(); sent_data.delete();
        end else begin
            case (eng_st)
                0: if (!hang && !a_if.enable_send_n) begin
                    sent_addr.push_back(a_if.slave_address);
                    sent_reg.push_back(a_if.slave_register);
                    sent_data.push_back(a_if.slave_data);
                    a_if.eng_busy_n = 1'b0; a_if.eng_status = 8'h00;
                    eng_cnt = busy_len; eng_st = 2;
                end
                2: begin
                    eng_cnt = eng_cnt - 1;
                    if (eng_cnt == 0) begin
                        a_if.eng_busy_n = 1'b1;
                        if (int'(a_if.slave_register) == fail_entry && fails_done < fail_times) begin
                            a_if.eng_status = fail_code; fails_done = fails_done + 1;
                        end else begin
                            a_if.eng_status = 8'h2A;
                        end
                        eng_st = 3;
                    end
                end
                3: if (a_if.enable_send_n) eng_st = 0;
                default: eng_st = 0;
            endcase
        end
    end

    int tests = 0, failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_en"}, a_if.enable_send_n, 1'b1);
        chk({tag, "_done"}, a_done, 1'b0);
        chk({tag, "_error"}, a_error, 1'b0);
        chk({tag, "_index"}, a_idx, 8'd0);
        chk({tag, "_fidx"}, a_fidx, 8'd0);
        chk({tag, "_last"}, a_last, 8'd0);
        chk({tag, "_retry"}, a_retry, 4'd0);
        chk({tag, "_saddr"}, a_if.slave_address, 8'd0);
        chk({tag, "_sreg"}, a_if.slave_register, 8'd0);
        chk({tag, "_sdata"}, a_if.slave_data, 8'd0);
    endtask

    typedef struct {
        int fe; int ft; logic [7:0] code; bit pulse_mid;
        bit exp_done; bit exp_err; logic [7:0] exp_fidx; logic [7:0] exp_last;
        logic [3:0] exp_retry; int exp_pulses;
    } scn_t;

    task automatic run_scn(input scn_t s, input int n);
        bit ok, pulsed;
        int exp_q[$];
        string tag;
        tag = $sformatf("scn%0d", n);
        hang = 1'b0; fail_entry = s.fe; fail_times = s.ft; fail_code = s.code;
        eng_rst = 1'b1; tick(); eng_rst = 1'b0;
        a_start = 1'b1; tick(); a_start = 1'b0;
        ok = 1'b0; pulsed = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (s.pulse_mid && !pulsed && !a_if.eng_busy_n && a_idx == 8'd1) begin
                a_start = 1'b1; tick(); a_start = 1'b0; pulsed = 1'b1;
            end
            if (a_done || a_error) begin ok = 1'b1; break; end
        end
        chk({tag, "_finished"}, ok, 1'b1);
        if (s.pulse_mid) chk({tag, "_pulsed"}, pulsed, 1'b1);
        chk({tag, "_done"}, a_done, s.exp_done);
        chk({tag, "_error"}, a_error, s.exp_err);
        chk({tag, "_last"}, a_last, s.exp_last);
        chk({tag, "_retry"}, a_retry, s.exp_retry);
        chk({tag, "_en"}, a_if.enable_send_n, 1'b1);
        if (s.exp_err) chk({tag, "_fidx"}, a_fidx, s.exp_fidx);
        chk({tag, "_pulses"}, sent_reg.size(), s.exp_pulses);
        for (int e = 0; e < 3; e++) begin
            int att;
            bit dies;
            dies = (e == s.fe) && (s.ft > 2);
            att = (e == s.fe) ? (dies ? 3 : s.ft + 1) : 1;
            for (int k = 0; k < att; k++) exp_q.push_back(e);
            if (dies) break;
        end
        for (int i = 0; i < exp_q.size() && i < sent_reg.size(); i++) begin
            chk($sformatf("%s_reg%0d", tag, i), sent_reg[i], 8'(exp_q[i]));
            chk($sformatf("%s_data%0d", tag, i), sent_data[i], exp_data(exp_q[i]));
            chk($sformatf("%s_addr%0d", tag, i), sent_addr[i], 8'h78);
        end
    endtask

    task automatic wait_a_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (a_done) begin ok = 1'b1; break; end
        end
        chk(tag, ok, 1'b1);
    endtask

    scn_t scns[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int k;
        scn_t s0;
        scns[0] = '{0, 0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h2A, 4'd0, 3};
        scns[1] = '{1, 2, 8'h29, 1'b0, 1'b1, 1'b0, 8'h00, 8'h2A, 4'd0, 5};
        scns[2] = '{0, 99, 8'h25, 1'b0, 1'b0, 1'b1, 8'h00, 8'h25, 4'd2, 3};
        scns[3] = '{2, 2, 8'h30, 1'b0, 1'b1, 1'b0, 8'h00, 8'h2A, 4'd0, 5};
        scns[4] = '{2, 99, 8'h20, 1'b0, 1'b0, 1'b1, 8'h02, 8'h20, 4'd2, 5};

        reset = 1'b0; a_start = 1'b0; b_start = 1'b0;
        b_if.eng_busy_n = 1'b1; b_if.eng_status = 8'h00;
        tick(); tick(); tick();
        chk_reset_a("por");
        chk("por_b_en", b_if.enable_send_n, 1'b1);
        reset = 1'b1; eng_rst = 1'b0;
        tick();

        // Single-entry run with exact handshake timing and no gap before done.
        b_start = 1'b1; tick(); b_start = 1'b0;
        chk("b_load_en", b_if.enable_send_n, 1'b1);
        tick();
        chk("b_saddr", b_if.slave_address, 8'h3C);
        chk("b_sreg", b_if.slave_register, 8'h55);
        chk("b_sdata", b_if.slave_data, 8'hA5);
        chk("b_assert_en", b_if.enable_send_n, 1'b1);
        tick();
        chk("b_en_low", b_if.enable_send_n, 1'b0);
        b_if.eng_busy_n = 1'b0;
        tick(); tick(); tick();
        b_if.eng_busy_n = 1'b1; b_if.eng_status = 8'h2A;
        tick();
        chk("b_check_done", b_done, 1'b0);
        tick();
        chk("b_release_done", b_done, 1'b0);
        chk("b_release_en", b_if.enable_send_n, 1'b0);
        tick();
        chk("b_done", b_done, 1'b1);
        chk("b_done_en", b_if.enable_send_n, 1'b1);
        chk("b_done_last", b_last, 8'h2A);
        chk("b_done_err", b_error, 1'b0);
        chk("b_done_idx", b_idx, 8'd0);

        // Engine never goes busy: ACK status must not rescue a timed-out attempt.
        b_start = 1'b1; tick(); b_start = 1'b0;
        tick(); tick();
        chk("b_to_en_low", b_if.enable_send_n, 1'b0);
        k = 0; ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick(); k++;
            if (b_error) begin ok = 1'b1; break; end
        end
        chk("b_to_reached", ok, 1'b1);
        chk("b_to_cycles", k, 13);
        chk("b_to_en", b_if.enable_send_n, 1'b1);
        chk("b_to_done", b_done, 1'b0);
        chk("b_to_fidx", b_fidx, 8'd0);
        chk("b_to_last", b_last, 8'h2A);
        chk("b_to_retry", b_retry, 4'd0);

        for (int i = 0; i < 5; i++) run_scn(scns[i], i);

        // Reset in WAIT_DONE of entry 2, then a clean rerun from entry 0.
        hang = 1'b0; fail_times = 0;
        eng_rst = 1'b1; tick(); eng_rst = 1'b0;
        a_start = 1'b1; tick(); a_start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (a_idx == 8'd2 && !a_if.eng_busy_n) begin ok = 1'b1; break; end
        end
        chk("mid_found", ok, 1'b1);
        chk("mid_en_low", a_if.enable_send_n, 1'b0);
        reset = 1'b0; tick();
        chk_reset_a("mid");
        reset = 1'b1;
        s0 = scns[0]; s0.pulse_mid = 1'b0;
        run_scn(s0, 5);

        // Start held high: DONE restarts on the next edge.
        fail_times = 0;
        eng_rst = 1'b1; tick(); eng_rst = 1'b0;
        a_start = 1'b1;
        wait_a_done("hold_first_done");
        tick();
        chk("hold_done_clear", a_done, 1'b0);
        chk("hold_idx0", a_idx, 8'd0);
        chk("hold_en", a_if.enable_send_n, 1'b1);
        a_start = 1'b0;
        wait_a_done("hold_second_done");
        chk("hold_pulses", sent_reg.size(), 6);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
